// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-requester APB master.
//   apb_state_t     : bus FSM states (IDLE, SETUP, ACCESS, DONE)
//   APB_ADDR_W      : APB address width (8)
//   APB_DATA_W      : APB data width (32)
//   TIMEOUT_CYCLES  : ACCESS cycles without pready before a forced completion
//                     (only used when APB_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int APB_ADDR_W     = 8;
    localparam int APB_DATA_W     = 32;
    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int WAIT_CNT_W     = 4;

    // Counter value seen during the last tolerated ACCESS cycle without pready.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

    // Requester index -> one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return {idx, ~idx};
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin arbiter. A lone request always wins; when both
// requesters are active, the one that was not granted last wins. The
// last-grant pointer resets to 1 so requester 0 wins the first contention.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_req[1:0]     : (already masked) request vector
//   i_take         : grant is consumed this cycle; update the pointer
//   o_grant_valid  : at least one request present
//   o_grant_idx    : index of the winning requester
// ---------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_take,
    output logic               o_grant_valid,
    output logic               o_grant_idx
);

    logic r_last;
    logic w_idx;

    // Both requesting: pick the one not served last. Otherwise the single
    // active bit decides (bit 1 set alone -> 1, bit 0 set alone -> 0).
    always_comb begin
        w_idx = i_req[1];
        if (i_req == 2'b11) begin
            w_idx = ~r_last;
        end
    end

    assign o_grant_valid = |i_req;
    assign o_grant_idx   = w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_take && o_grant_valid) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// ---------------------------------------------------------------------------
// apb_arb_master
// APB master shared by two requesters through a round-robin arbiter.
// Transfer flow: IDLE -> SETUP -> ACCESS (wait for pready) -> DONE -> IDLE,
// so at least one idle bus cycle always separates two transfers.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req[1:0], req_write[1:0]   : per-requester request / direction (1 = write)
//   req_addr0/1, req_wdata0/1  : per-requester address / write data
//   ack[1:0]                   : one-cycle completion pulse to the granted requester
//   rdata                      : read data of the last completed read
//   err                        : error flag, meaningful only while ack != 0
//   psel, penable, pwrite, paddr, pwdata : APB master outputs
//   prdata, pready             : APB slave response
// Build option:
//   APB_TIMEOUT_EN : when defined, ACCESS gives up after TIMEOUT_CYCLES
//                    cycles without pready, completing with err=1, rdata=0.
//                    When undefined, ACCESS waits forever and err is 0.
// ---------------------------------------------------------------------------
module apb_arb_master
    import apb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [APB_ADDR_W-1:0] req_addr0,
    input  logic [APB_ADDR_W-1:0] req_addr1,
    input  logic [APB_DATA_W-1:0] req_wdata0,
    input  logic [APB_DATA_W-1:0] req_wdata1,
    output logic [NUM_REQ-1:0]    ack,
    output logic [APB_DATA_W-1:0] rdata,
    output logic                  err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready
);

    apb_state_t            r_state;
    logic                  r_grant;
    logic [NUM_REQ-1:0]    r_ack;
    logic [APB_DATA_W-1:0] r_rdata;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [APB_ADDR_W-1:0] r_paddr;
    logic [APB_DATA_W-1:0] r_pwdata;
`ifdef APB_TIMEOUT_EN
    logic                  r_err;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
`endif

    logic [NUM_REQ-1:0]    w_req_masked;
    logic                  w_take;
    logic                  w_grant_valid;
    logic                  w_grant_idx;
    logic                  w_sel_write;
    logic [APB_ADDR_W-1:0] w_sel_addr;
    logic [APB_DATA_W-1:0] w_sel_wdata;

    // The requester being acked still has req high during DONE; hide it so
    // it cannot look like a fresh request in that cycle.
    assign w_req_masked = req & ~((r_state == DONE) ? idx_to_onehot(r_grant) : '0);
    assign w_take       = (r_state == IDLE);

    apb_rr_arbiter u_arbiter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (w_req_masked),
        .i_take        (w_take),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Winner's transfer attributes, captured on IDLE -> SETUP.
    assign w_sel_write = w_grant_idx ? req_write[1] : req_write[0];
    assign w_sel_addr  = w_grant_idx ? req_addr1    : req_addr0;
    assign w_sel_wdata = w_grant_idx ? req_wdata1   : req_wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
`ifdef APB_TIMEOUT_EN
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
`endif
        end else begin
            // ack and err are single-cycle pulses in DONE.
            r_ack <= '0;
`ifdef APB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (w_grant_valid) begin
                        r_state  <= SETUP;
                        r_grant  <= w_grant_idx;
                        r_psel   <= 1'b1;
                        r_pwrite <= w_sel_write;
                        r_paddr  <= w_sel_addr;
                        r_pwdata <= w_sel_wdata;
                    end
                end

                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end

                ACCESS: begin
                    if (pready) begin
                        r_state   <= DONE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ack     <= idx_to_onehot(r_grant);
                        if (!r_pwrite) begin
                            r_rdata <= prdata;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_LAST) begin
                        // Slave never answered: complete with an error.
                        r_state   <= DONE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_ack     <= idx_to_onehot(r_grant);
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
`ifdef APB_TIMEOUT_EN
    assign err     = r_err;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_arb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_arb_master
// Directed bench for apb_arb_master: single write, read with wait states,
// round-robin contention, reset in the middle of ACCESS, and either the
// timeout path (APB_TIMEOUT_EN) or an indefinite wait (default build).
// ---------------------------------------------------------------------------
module tb_apb_arb_master;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [7:0]  req_addr0;
    logic [7:0]  req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int n_checks;
    int n_fail;
    int cnt;
    int idle;
    int bursts;
    int n_ack;
    logic done;
    logic prev_psel;
    logic ack_seen;
    logic err_seen;
    logic [1:0] exp_ack [4];

    apb_arb_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req        = 2'b00;
        req_write  = 2'b00;
        req_addr0  = 8'h00;
        req_addr1  = 8'h00;
        req_wdata0 = 32'h0;
        req_wdata1 = 32'h0;
        prdata     = 32'h0;
        pready     = 1'b0;
        exp_ack    = '{2'b01, 2'b10, 2'b01, 2'b10};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_psel",    32'(psel),    32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_ack",     32'(ack),     32'd0);
        check("rst_rdata",   rdata,        32'h0);
        check("rst_paddr",   32'(paddr),   32'd0);
        check("rst_err",     32'(err),     32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- single write, requester 0 ----------------
        req_write  = 2'b01;
        req_addr0  = 8'h10;
        req_wdata0 = 32'hA5A5_0001;
        prdata     = 32'h1234_5678;   // must not be captured on a write
        pready     = 1'b1;            // high outside ACCESS: ignored
        req        = 2'b01;           // cycle N
        tick();                       // N+1
        check("wr_setup_psel",    32'(psel),    32'd1);
        check("wr_setup_penable", 32'(penable), 32'd0);
        check("wr_setup_paddr",   32'(paddr),   32'h10);
        check("wr_setup_pwdata",  pwdata,       32'hA5A5_0001);
        check("wr_setup_pwrite",  32'(pwrite),  32'd1);
        tick();                       // N+2
        check("wr_access_penable", 32'(penable), 32'd1);
        check("wr_access_paddr",   32'(paddr),   32'h10);
        tick();                       // N+3
        check("wr_ack",   32'(ack),  32'h1);
        check("wr_err",   32'(err),  32'd0);
        check("wr_psel",  32'(psel), 32'd0);
        check("wr_rdata_held", rdata, 32'h0);
        req    = 2'b00;
        pready = 1'b0;
        tick();
        check("wr_ack_pulse", 32'(ack), 32'd0);

        // ---------------- read with 3 ACCESS cycles, requester 1 ----------------
        req_write = 2'b00;
        req_addr1 = 8'h24;
        req       = 2'b10;
        tick();
        check("rd_setup_psel",   32'(psel),    32'd1);
        check("rd_setup_penable",32'(penable), 32'd0);
        check("rd_setup_paddr",  32'(paddr),   32'h24);
        check("rd_setup_pwrite", 32'(pwrite),  32'd0);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (penable) begin
                cnt++;
                if (cnt == 3) begin
                    pready = 1'b1;
                    prdata = 32'hDEAD_BEEF;
                end else begin
                    pready = 1'b0;
                end
            end else begin
                done = 1'b1;
            end
        end
        check("rd_bound",        32'(done), 32'd1);
        check("rd_penable_cyc",  32'(cnt),  32'd3);
        check("rd_ack",          32'(ack),  32'h2);
        check("rd_err",          32'(err),  32'd0);
        check("rd_rdata",        rdata,     32'hDEAD_BEEF);
        req    = 2'b00;
        pready = 1'b0;
        prdata = 32'h0;
        tick();

        // ---------------- contention: both requesters held ----------------
        req_write = 2'b00;
        req_addr0 = 8'h30;
        req_addr1 = 8'h31;
        pready    = 1'b1;
        req       = 2'b11;
        n_ack     = 0;
        idle      = 0;
        bursts    = 0;
        prev_psel = 1'b0;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            tick();
            prdata = 32'hCAFE_0000 | 32'(paddr);
            if (psel) begin
                if (!prev_psel) begin
                    if (bursts > 0) begin
                        check($sformatf("cont_gap%0d", bursts), 32'(idle >= 1), 32'd1);
                    end
                    bursts++;
                end
                idle = 0;
            end else begin
                idle++;
            end
            prev_psel = psel;
            if (ack != 2'b00) begin
                check($sformatf("cont_ack%0d", n_ack), 32'(ack), 32'(exp_ack[n_ack]));
                n_ack++;
                if (n_ack == 4) begin
                    req = 2'b00;
                end
            end
        end
        check("cont_n_ack", 32'(n_ack), 32'd4);
        check("cont_rdata", rdata,      32'hCAFE_0031);
        pready = 1'b0;
        prdata = 32'h0;
        tick();

        // ---------------- reset in the second ACCESS cycle ----------------
        req_addr0 = 8'h40;
        req_addr1 = 8'h41;
        req_write = 2'b00;
        req       = 2'b01;
        tick();                       // SETUP (requester 0 -> last grant 0)
        tick();                       // ACCESS 1
        check("rst_mid_acc1", 32'(penable), 32'd1);
        tick();                       // ACCESS 2
        check("rst_mid_acc2", 32'(penable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_psel",    32'(psel),    32'd0);
        check("rst_mid_penable", 32'(penable), 32'd0);
        check("rst_mid_ack",     32'(ack),     32'd0);
        check("rst_mid_rdata",   rdata,        32'h0);
        req = 2'b00;
        tick();
        check("rst_mid_noack", 32'(ack), 32'd0);
        tick();
        rst_n = 1'b1;
        req   = 2'b11;
        tick();
        check("rst_resume_psel",  32'(psel),  32'd1);
        check("rst_resume_paddr", 32'(paddr), 32'h40);
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        tick();
        req = 2'b00;
        tick();
        check("rst_resume_ack",   32'(ack), 32'h1);
        check("rst_resume_rdata", rdata,    32'h5555_AAAA);
        pready = 1'b0;
        prdata = 32'h0;
        tick();

`ifdef APB_TIMEOUT_EN
        // ---------------- timeout: pready never arrives ----------------
        prdata    = 32'h7777_7777;
        req_write = 2'b00;
        req       = 2'b01;
        tick();                       // SETUP
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (penable) begin
                cnt++;
            end else begin
                done = 1'b1;
            end
        end
        check("to_bound",      32'(done), 32'd1);
        check("to_access_cyc", 32'(cnt),  32'd16);
        check("to_ack",        32'(ack),  32'h1);
        check("to_err",        32'(err),  32'd1);
        check("to_rdata",      rdata,     32'h0);
        req = 2'b00;
        tick();
        check("to_err_pulse",  32'(err),  32'd0);
`else
        // ---------------- no timeout: ACCESS waits indefinitely ----------------
        req_write = 2'b00;
        req       = 2'b01;
        pready    = 1'b0;
        tick();                       // SETUP
        cnt      = 0;
        ack_seen = 1'b0;
        err_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (psel && penable) cnt++;
            if (ack != 2'b00) ack_seen = 1'b1;
            if (err) err_seen = 1'b1;
        end
        check("nto_access_cyc", 32'(cnt),      32'd40);
        check("nto_no_ack",     32'(ack_seen), 32'd0);
        check("nto_no_err",     32'(err_seen), 32'd0);
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        tick();
        req = 2'b00;
        check("nto_ack",   32'(ack), 32'h1);
        check("nto_err",   32'(err), 32'd0);
        check("nto_rdata", rdata,    32'h0BAD_F00D);
        pready = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
